// File: rtl/i2c_target.sv
// I2C target (responder) with a small CPU register interface.
// Answers one 7-bit address. Bytes written by the initiator land in RXDATA;
// bytes read by the initiator come from TXDATA, or 0xFF when TXDATA is empty.
// SDA is open-drain: sdaOe=1 pulls the line low. SCL is never stretched.
module i2c_target #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] RESET_ADDR  = 7'h42
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [1:0]  address,
    input  logic [31:0] dataIn,
    output logic        readValid,
    output logic [31:0] dataOut,
    output logic        irq,
    input  logic        sclIn,
    input  logic        sdaIn,
    output logic        sdaOe
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl, sda, scl_q, sda_q;
    logic scl_rise, scl_fall, start, stop;

    logic       enable;
    logic [6:0] own_addr;
    logic [7:0] rx_data, tx_data, shreg, tx_sh, tx_next;
    logic [2:0] bit_cnt;
    logic       got8;
    logic       rx_full, tx_empty, rx_overrun, dir_read, stop_seen, tx_req;
    logic       addressed, match;
    logic [31:0] read_mux;
    logic       unused_bits;

    assign unused_bits = ^dataIn[31:8];

    assign scl = scl_sync[SYNC_STAGES-1];
    assign sda = sda_sync[SYNC_STAGES-1];

    // Line events, all taken from the synchronised pins
    assign scl_rise = scl & ~scl_q;
    assign scl_fall = ~scl & scl_q;
    assign start    = scl & scl_q & sda_q & ~sda;
    assign stop     = scl & scl_q & ~sda_q & sda;

    // Only the data phases count as "addressed"; IDLE/ADDR/WAIT_STOP do not
    assign addressed = (state == ADDR_ACK) || (state == RX_DATA) || (state == RX_ACK) ||
                       (state == TX_DATA) || (state == TX_ACK);

    // Own address 0 is reserved for general call, which this target ignores
    assign match = (own_addr != 7'd0) && (shreg[7:1] == own_addr);

    // Byte handed to the initiator at the end of each ACK phase
    assign tx_next = tx_empty ? 8'hFF : tx_data;

    assign irq = rx_full | tx_req | stop_seen;

    // Synchroniser chains; the idle bus level is high on both lines
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], sclIn};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sdaIn};
            scl_q    <= scl;
            sda_q    <= sda;
        end
    end

    // Register file read mux
    always_comb begin
        read_mux = 32'd0;
        case (address)
            2'd0: read_mux = {24'd0, enable, own_addr};
            2'd2: read_mux = {24'd0, rx_data};
            2'd3: read_mux = {25'd0, tx_req, stop_seen, dir_read, rx_overrun,
                              addressed, tx_empty, rx_full};
            default: read_mux = 32'd0;
        endcase
    end

    // CPU read port: data presented exactly one cycle after the strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readValid <= 1'b0;
            dataOut   <= 32'd0;
        end else begin
            readValid <= read;
            dataOut   <= read ? read_mux : 32'd0;
        end
    end

    // Register writes and the bus FSM; FSM sets come last so they beat CPU clears
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sdaOe      <= 1'b0;
            enable     <= 1'b0;
            own_addr   <= RESET_ADDR;
            rx_data    <= 8'h00;
            tx_data    <= 8'hFF;
            shreg      <= 8'h00;
            tx_sh      <= 8'hFF;
            bit_cnt    <= 3'd0;
            got8       <= 1'b0;
            rx_full    <= 1'b0;
            tx_empty   <= 1'b1;
            rx_overrun <= 1'b0;
            dir_read   <= 1'b0;
            stop_seen  <= 1'b0;
            tx_req     <= 1'b0;
        end else begin
            if (write) begin
                case (address)
                    2'd0: begin
                        own_addr <= dataIn[6:0];
                        enable   <= dataIn[7];
                    end
                    2'd1: begin
                        tx_data  <= dataIn[7:0];
                        tx_empty <= 1'b0;
                        tx_req   <= 1'b0;
                    end
                    2'd3: begin
                        if (dataIn[3]) rx_overrun <= 1'b0;
                        if (dataIn[5]) stop_seen  <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (read && address == 2'd2) rx_full <= 1'b0;

            if (!enable) begin
                state <= IDLE;
                sdaOe <= 1'b0;
            end else if (start) begin
                state   <= ADDR;
                bit_cnt <= 3'd0;
                got8    <= 1'b0;
                sdaOe   <= 1'b0;
            end else if (stop) begin
                if (addressed) stop_seen <= 1'b1;
                state <= IDLE;
                sdaOe <= 1'b0;
            end else begin
                // Every SCL rise samples a bit; phases that ignore it reset the count on exit
                if (scl_rise) begin
                    shreg   <= {shreg[6:0], sda};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) got8 <= 1'b1;
                end
                case (state)
                    IDLE, WAIT_STOP: ;
                    ADDR: begin
                        if (scl_fall && got8) begin
                            got8    <= 1'b0;
                            bit_cnt <= 3'd0;
                            if (match) begin
                                state    <= ADDR_ACK;
                                sdaOe    <= 1'b1;
                                dir_read <= shreg[0];
                            end else begin
                                state <= WAIT_STOP;
                                sdaOe <= 1'b0;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 3'd0;
                            got8    <= 1'b0;
                            if (dir_read) begin
                                state    <= TX_DATA;
                                tx_sh    <= tx_next;
                                sdaOe    <= ~tx_next[7];
                                tx_empty <= 1'b1;
                            end else begin
                                state <= RX_DATA;
                                sdaOe <= 1'b0;
                            end
                        end
                    end
                    RX_DATA: begin
                        if (scl_fall && got8) begin
                            got8    <= 1'b0;
                            bit_cnt <= 3'd0;
                            if (!rx_full) begin
                                rx_data <= shreg;
                                rx_full <= 1'b1;
                                sdaOe   <= 1'b1;
                                state   <= RX_ACK;
                            end else begin
                                rx_overrun <= 1'b1;
                                sdaOe      <= 1'b0;
                                state      <= WAIT_STOP;
                            end
                        end
                    end
                    RX_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 3'd0;
                            got8    <= 1'b0;
                            sdaOe   <= 1'b0;
                            state   <= RX_DATA;
                        end
                    end
                    TX_DATA: begin
                        if (scl_fall) begin
                            if (got8) begin
                                got8    <= 1'b0;
                                bit_cnt <= 3'd0;
                                sdaOe   <= 1'b0;
                                state   <= TX_ACK;
                            end else begin
                                tx_sh <= {tx_sh[6:0], 1'b0};
                                sdaOe <= ~tx_sh[6];
                            end
                        end
                    end
                    TX_ACK: begin
                        // Only an ACK keeps us here long enough to see the fall
                        if (scl_rise) begin
                            if (sda) state  <= WAIT_STOP;
                            else     tx_req <= 1'b1;
                        end else if (scl_fall) begin
                            bit_cnt  <= 3'd0;
                            got8     <= 1'b0;
                            state    <= TX_DATA;
                            tx_sh    <= tx_next;
                            sdaOe    <= ~tx_next[7];
                            tx_empty <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged I2C initiator plus CPU register
// accesses, with hand-computed expected values.
module tb_i2c_target;

    localparam int QC = 6;  // system clocks per quarter SCL period

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        read = 1'b0, write = 1'b0;
    logic [1:0]  address = 2'd0;
    logic [31:0] dataIn = 32'd0;
    logic        readValid, irq, sdaOe;
    logic [31:0] dataOut;
    logic        scl_m = 1'b1, sda_m = 1'b1;
    logic        sda_line;
    int          total = 0, bad = 0;
    int          oe_cnt = 0;

    assign sda_line = sda_m & ~sdaOe;

    i2c_target dut (
        .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
        .dataIn(dataIn), .readValid(readValid), .dataOut(dataOut), .irq(irq),
        .sclIn(scl_m), .sdaIn(sda_line), .sdaOe(sdaOe)
    );

    always #5 clk = ~clk;

    // Counts cycles with SDA pulled by the target
    always @(posedge clk) if (sdaOe) oe_cnt <= oe_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic q();
        repeat (QC) @(negedge clk);
    endtask

    task automatic cpu_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        write = 1'b1; address = a; dataIn = d;
        @(negedge clk);
        write = 1'b0; dataIn = 32'd0;
    endtask

    task automatic cpu_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        read = 1'b1; address = a;
        @(negedge clk);
        read = 1'b0;
        chk("readValid", {31'd0, readValid}, 32'd1);
        d = dataOut;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; q(); scl_m = 1'b1; q(); sda_m = 1'b0; q(); scl_m = 1'b0; q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; q(); scl_m = 1'b1; q(); sda_m = 1'b1; q();
    endtask

    task automatic bit_io(input logic b, output logic s);
        sda_m = b; q(); scl_m = 1'b1; q(); s = sda_line; q(); scl_m = 1'b0; q();
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_io(d[i], s);
        bit_io(1'b1, s);
        ack = ~s;
    endtask

    task automatic rbyte(input logic ack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_io(1'b1, s);
            d = {d[6:0], s};
        end
        bit_io(~ack, s);
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  b;
        logic        a;
        int          oe0;

        // Reset state
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_sdaOe", {31'd0, sdaOe}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_dataOut", dataOut, 32'd0);
        cpu_rd(2'd3, r); chk("rst_status", r, 32'h02);
        cpu_rd(2'd2, r); chk("rst_rxdata", r, 32'h00);
        @(negedge clk);
        chk("rv_drop", {31'd0, readValid}, 32'd0);

        cpu_wr(2'd0, 32'hC2);
        cpu_rd(2'd0, r); chk("control", r, 32'hC2);
        cpu_wr(2'd1, 32'h5A);
        cpu_rd(2'd3, r); chk("tx_loaded", r, 32'h00);

        // Write 0xA5 to address 0x42
        i2c_start();
        wbyte(8'h84, a); chk("w_addr_ack", {31'd0, a}, 32'd1);
        wbyte(8'hA5, a); chk("w_data_ack", {31'd0, a}, 32'd1);
        i2c_stop();
        cpu_rd(2'd3, r); chk("w_status", r, 32'h21);
        chk("w_irq", {31'd0, irq}, 32'd1);
        cpu_wr(2'd3, 32'h20);

        // Second write while RXDATA still full
        i2c_start();
        wbyte(8'h84, a); chk("ov_addr_ack", {31'd0, a}, 32'd1);
        wbyte(8'h3C, a); chk("ov_nack", {31'd0, a}, 32'd0);
        i2c_stop();
        cpu_rd(2'd3, r); chk("ov_status", r, 32'h09);
        cpu_rd(2'd2, r); chk("ov_rxdata", r, 32'hA5);
        cpu_rd(2'd3, r); chk("rx_cleared", r, 32'h08);
        cpu_wr(2'd3, 32'h08);
        cpu_rd(2'd3, r); chk("ov_w1c", r, 32'h00);
        chk("irq_low", {31'd0, irq}, 32'd0);

        // Read two bytes: TXDATA then the empty filler
        i2c_start();
        wbyte(8'h85, a); chk("r_addr_ack", {31'd0, a}, 32'd1);
        rbyte(1'b1, b); chk("r_byte0", {24'd0, b}, 32'h5A);
        rbyte(1'b0, b); chk("r_byte1", {24'd0, b}, 32'hFF);
        i2c_stop();
        cpu_rd(2'd3, r); chk("r_status", r, 32'h52);
        chk("r_irq", {31'd0, irq}, 32'd1);

        // Foreign address, then repeated STARTs
        oe0 = oe_cnt;
        i2c_start();
        wbyte(8'h10, a); chk("foreign_nack", {31'd0, a}, 32'd0);
        chk("foreign_no_oe", oe_cnt - oe0, 32'd0);
        i2c_start();
        wbyte(8'h85, a); chk("rs_rd_ack", {31'd0, a}, 32'd1);
        rbyte(1'b1, b); chk("rs_rd_byte", {24'd0, b}, 32'hFF);
        i2c_start();
        wbyte(8'h84, a); chk("rs_wr_ack", {31'd0, a}, 32'd1);
        cpu_rd(2'd3, r); chk("rs_status", r, 32'h46);
        i2c_stop();
        cpu_rd(2'd3, r); chk("rs_stop", r, 32'h62);

        // Reset in the middle of a transmitted byte
        cpu_wr(2'd1, 32'h00);
        i2c_start();
        wbyte(8'h85, a); chk("rst_addr_ack", {31'd0, a}, 32'd1);
        for (int i = 0; i < 4; i++) bit_io(1'b1, a);
        chk("tx_driving", {31'd0, sdaOe}, 32'd1);
        @(posedge clk); #1 reset = 1'b1;
        #1 chk("rst_release", {31'd0, sdaOe}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cpu_wr(2'd0, 32'hC2);
        i2c_stop();
        cpu_rd(2'd3, r); chk("rst_stop_ign", r, 32'h02);
        chk("rst_irq2", {31'd0, irq}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
